// File: rtl/mips_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | mips_pkg : reset vector, opcode constants, fetch FSM encoding    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } if_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | if_id_reg : IF/ID pipeline register with stall hold, flush and   |
// |             a one-entry buffer for responses that meet a stall   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module if_id_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_load_rsp,
  input  logic        i_capture,
  input  logic        i_load_buf,
  input  logic [31:0] i_rsp_data,
  input  logic [31:0] i_rsp_pc4,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_buf_valid;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc4;

  // Flush beats every load; a plain stall freezes all fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= 32'h0;
      r_pc4   <= 32'h0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load_rsp) begin
      r_valid <= 1'b1;
      r_instr <= i_rsp_data;
      r_pc4   <= i_rsp_pc4;
    end else if (i_load_buf) begin
      r_valid <= r_buf_valid;
      r_instr <= r_buf_instr;
      r_pc4   <= r_buf_pc4;
    end else if (!i_stall) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_valid <= 1'b0;
      r_buf_instr <= 32'h0;
      r_buf_pc4   <= 32'h0;
    end else if (i_flush || i_load_buf) begin
      r_buf_valid <= 1'b0;
    end else if (i_capture) begin
      r_buf_valid <= 1'b1;
      r_buf_instr <= i_rsp_data;
      r_buf_pc4   <= i_rsp_pc4;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | if_stage : instruction fetch with one outstanding imem request,  |
// |            stall buffering and branch redirect                   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module if_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [5:0]  opcode
);

  import mips_pkg::*;

  if_state_e   r_state;
  if_state_e   w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        w_req_valid;
  logic        w_fire;
  logic        w_rsp_take;
  logic        w_load_rsp;
  logic        w_capture;
  logic        w_load_buf;
  logic        w_unused_ok;

  // Gating on rst_n keeps the request low while reset is held.
  assign w_req_valid = rst_n && (r_state == FETCH) && !redirect;
  assign w_fire      = w_req_valid && imem_req_ready;
  assign w_rsp_take  = (r_state == WAIT) && imem_rsp_valid && !redirect;
  assign w_load_rsp  = w_rsp_take && !stall;
  assign w_capture   = w_rsp_take && stall;
  assign w_load_buf  = (r_state == HOLD) && !stall && !redirect;
  assign w_unused_ok = &{1'b0, redirect_pc[1:0]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH: if (w_fire) w_state_nxt = WAIT;
      WAIT: begin
        if (redirect)            w_state_nxt = imem_rsp_valid ? FETCH : DRAIN;
        else if (imem_rsp_valid) w_state_nxt = stall ? HOLD : FETCH;
      end
      HOLD:  if (redirect || !stall) w_state_nxt = FETCH;
      // The in-flight response retires DRAIN even if a new redirect coincides.
      DRAIN: if (imem_rsp_valid) w_state_nxt = FETCH;
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (redirect)    r_pc <= {redirect_pc[31:2], 2'b00};
      else if (w_fire) r_pc <= pc_plus4(r_pc);
      if (w_fire)      r_req_pc <= r_pc;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_stall    (stall),
    .i_flush    (redirect),
    .i_load_rsp (w_load_rsp),
    .i_capture  (w_capture),
    .i_load_buf (w_load_buf),
    .i_rsp_data (imem_rsp_data),
    .i_rsp_pc4  (pc_plus4(r_req_pc)),
    .o_valid    (if_id_valid),
    .o_instr    (if_id_instr),
    .o_pc4      (if_id_pc4)
  );

  assign imem_req_valid = w_req_valid;
  assign imem_addr      = r_pc;
  assign opcode         = if_id_instr[31:26];

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_if_stage : directed bench with address and IF/ID scoreboards  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_if_stage;

  import mips_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ld_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [5:0]  opcode;

  ld_t         ld_q[$];
  logic [31:0] addr_q[$];
  ld_t         last;
  int          n_pass = 0;
  int          n_total = 0;
  logic        obs_req;
  logic [31:0] obs_addr;

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4),
    .opcode         (opcode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, sample the request side, then let the edge happen.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rd,
                     input logic st, input logic rr, input logic [31:0] rpc);
    ld_t unused_dummy;
    unused_dummy   = '0;
    imem_req_ready = rdy;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    stall          = st;
    redirect       = rr;
    redirect_pc    = rpc;
    #1;
    obs_req  = imem_req_valid;
    obs_addr = imem_addr;
    if (imem_req_valid && rdy) begin
      if (addr_q.size() == 0) chk("unexpected_req", imem_addr, 32'hxxxx_xxxx);
      else                    chk("req_addr", imem_addr, addr_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_load(input string tag);
    ld_t e;
    e = ld_q.pop_front();
    chk({tag, "_valid"}, 32'(if_id_valid), 32'h1);
    chk({tag, "_instr"}, if_id_instr, e.instr);
    chk({tag, "_pc4"}, if_id_pc4, e.pc4);
    chk({tag, "_opcode"}, 32'(opcode), 32'(e.instr[31:26]));
    last = e;
  endtask

  task automatic check_hold(input string tag);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'h1);
    chk({tag, "_instr"}, if_id_instr, last.instr);
    chk({tag, "_pc4"}, if_id_pc4, last.pc4);
  endtask

  task automatic check_bubble(input string tag);
    chk(tag, 32'(if_id_valid), 32'h0);
  endtask

  initial begin
    last = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_if_id_valid", 32'(if_id_valid), 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h0);
    rst_n = 1'b1;

    // Basic fetch stream with one-cycle memory latency.
    addr_q.push_back(32'h0);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    chk("first_req", 32'(obs_req), 32'h1);
    ld_q.push_back({32'h8C22_0004, 32'h4});
    cyc(1, 1, 32'h8C22_0004, 0, 0, 32'h0);
    chk("wait_no_req", 32'(obs_req), 32'h0);
    check_load("lw");
    chk("lw_opcode_const", 32'(opcode), 32'(OP_LW));
    addr_q.push_back(32'h4);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    chk("next_req_m1", 32'(obs_req), 32'h1);
    check_bubble("bubble_after_lw");
    ld_q.push_back({32'h0022_1820, 32'h8});
    cyc(1, 1, 32'h0022_1820, 0, 0, 32'h0);
    check_load("rtype");

    // Stall across a returning response: buffered, then released.
    addr_q.push_back(32'h8);
    cyc(1, 0, 32'h0, 1, 0, 32'h0);
    check_hold("stall_fetch");
    cyc(1, 1, 32'hAC43_0008, 1, 0, 32'h0);
    check_hold("stall_rsp");
    cyc(1, 0, 32'h0, 1, 0, 32'h0);
    chk("hold_no_req1", 32'(obs_req), 32'h0);
    check_hold("hold1");
    cyc(1, 0, 32'h0, 1, 0, 32'h0);
    chk("hold_no_req2", 32'(obs_req), 32'h0);
    check_hold("hold2");
    ld_q.push_back({32'hAC43_0008, 32'hC});
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    chk("hold_release_no_req", 32'(obs_req), 32'h0);
    check_load("sw_buf");

    // Redirect in WAIT: late response dropped, target fetched word-aligned.
    addr_q.push_back(32'hC);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    cyc(1, 0, 32'h0, 0, 1, 32'h0000_0043);
    chk("redir_no_req", 32'(obs_req), 32'h0);
    check_bubble("redir_flush");
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    chk("drain_no_req1", 32'(obs_req), 32'h0);
    cyc(1, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
    chk("drain_no_req2", 32'(obs_req), 32'h0);
    check_bubble("drain_drop");
    addr_q.push_back(32'h40);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    chk("redir_target_req", 32'(obs_req), 32'h1);

    // Redirect coinciding with the response.
    cyc(1, 1, 32'h1022_0003, 0, 1, 32'h0000_0100);
    chk("redir_rsp_no_req", 32'(obs_req), 32'h0);
    check_bubble("redir_rsp_drop");
    addr_q.push_back(32'h100);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    chk("redir_rsp_target_req", 32'(obs_req), 32'h1);

    // A second redirect while draining retargets the PC.
    cyc(1, 0, 32'h0, 0, 1, 32'h0000_0200);
    cyc(1, 0, 32'h0, 0, 1, 32'h0000_0300);
    chk("drain_redir_no_req", 32'(obs_req), 32'h0);
    cyc(1, 1, 32'hCAFE_F00D, 0, 0, 32'h0);
    chk("drain2_no_req", 32'(obs_req), 32'h0);
    check_bubble("drain2_drop");
    addr_q.push_back(32'h300);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    ld_q.push_back({32'h8C00_0000, 32'h304});
    cyc(1, 1, 32'h8C00_0000, 0, 0, 32'h0);
    check_load("after_drain");

    // PC wrap at the top of the address space.
    cyc(1, 0, 32'h0, 0, 1, 32'hFFFF_FFFC);
    chk("wrap_redir_no_req", 32'(obs_req), 32'h0);
    addr_q.push_back(32'hFFFF_FFFC);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    ld_q.push_back({32'h0000_0020, 32'h0});
    cyc(1, 1, 32'h0000_0020, 0, 0, 32'h0);
    check_load("wrap_pc4");
    addr_q.push_back(32'h0);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    chk("wrap_req", 32'(obs_req), 32'h1);

    // Reset while a request is outstanding; its late response is ignored.
    imem_rsp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("midrst_valid", 32'(if_id_valid), 32'h0);
    chk("midrst_instr", if_id_instr, 32'h0);
    chk("midrst_pc4", if_id_pc4, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 1, 32'h1234_5678, 0, 0, 32'h0);
    chk("post_rst_req", 32'(obs_req), 32'h1);
    chk("post_rst_addr", obs_addr, 32'h0);
    check_bubble("late_rsp_ignored");
    addr_q.push_back(32'h0);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    check_bubble("post_rst_bubble");
    chk("addr_sb_drained", 32'(addr_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
